// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall, flush, halt-drain and EX forward-select control.
// Optional HZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_fwd_ctrl #(
  parameter int RA_W     = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic             id_use1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_wr,
  input  logic [RA_W-1:0]  id_rd2,
  input  logic             id_wr2,
  input  logic             id_load,
  input  logic             id_branch,
  input  logic             br_taken,
  input  logic             id_halt,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] LSTALL = 3'd1;
  localparam logic [2:0] BSTALL = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  // The raising RUN cycle is the first load stall, so LSTALL
  // only covers the remaining LOAD_LAT-1 cycles.
  localparam logic [2:0] LINIT =
    (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic [RA_W-1:0] rd2;
    logic            wr2;
    logic            ld;
  } sb_t;

  sb_t        sb_ex;
  sb_t        sb_mem;
  logic       wb_v;
  logic [2:0] state;
  logic [2:0] cnt;
  logic       stall;
  logic       adv;
  logic       lu;
  logic       bs;
  logic       hz_halt;
  logic       m1_ex;
  logic       m2_ex;
  logic       m1_mem;
  logic       m2_mem;
  logic [1:0] f1;
  logic [1:0] f2;
  logic       unused_ld;

  function automatic logic hit(input sb_t e,
                               input logic [RA_W-1:0] r);
    return e.v & ((e.wr & (e.rd == r)) |
                  (e.wr2 & (e.rd2 == r)));
  endfunction

  assign m1_ex  = id_use1 & hit(sb_ex, id_rs1);
  assign m2_ex  = id_use2 & hit(sb_ex, id_rs2);
  assign m1_mem = id_use1 & hit(sb_mem, id_rs1);
  assign m2_mem = id_use2 & hit(sb_mem, id_rs2);

  assign hz_halt = id_valid & id_halt;
  assign lu = id_valid & sb_ex.ld & (m1_ex | m2_ex);
  assign bs = id_valid & id_branch &
              (m1_ex | m2_ex | m1_mem | m2_mem);

  // MEM load flag has no consumer: a load there forwards like an ALU op
  assign unused_ld = sb_mem.ld;

  // Stall is combinational so the hazard-raising cycle already stalls
  always_comb begin
    stall = 1'b0;
    unique case (state)
      RUN:     stall = hz_halt | lu | bs;
      LSTALL:  stall = 1'b1;
      BSTALL:  stall = lu | bs;
      default: stall = 1'b1;
    endcase
  end

  assign adv = id_valid & ~stall;

  // Scoreboard shift and EX-aligned forward selects (EX wins over MEM)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      wb_v   <= 1'b0;
      f1     <= 2'd0;
      f2     <= 2'd0;
    end else begin
      sb_mem <= sb_ex;
      wb_v   <= sb_mem.v;
      if (adv) begin
        sb_ex.v   <= 1'b1;
        sb_ex.rd  <= id_rd;
        sb_ex.wr  <= id_wr;
        sb_ex.rd2 <= id_rd2;
        sb_ex.wr2 <= id_wr2;
        sb_ex.ld  <= id_load;
        f1 <= m1_ex ? 2'd1 : (m1_mem ? 2'd2 : 2'd0);
        f2 <= m2_ex ? 2'd1 : (m2_mem ? 2'd2 : 2'd0);
      end else begin
        sb_ex <= '0;
        f1    <= 2'd0;
        f2    <= 2'd0;
      end
    end
  end

  // Control state: halt beats load-use beats branch-operand stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz_halt) begin
            state <= DRAIN;
          end else if (lu) begin
            if (LOAD_LAT > 1) begin
              state <= LSTALL;
              cnt   <= LINIT;
            end
          end else if (bs) begin
            state <= BSTALL;
          end
        end
        LSTALL: begin
          if (cnt == 3'd0) state <= RUN;
          else cnt <= cnt - 3'd1;
        end
        BSTALL: begin
          if (!(lu | bs)) state <= RUN;
        end
        DRAIN: begin
          if (!(sb_ex.v | sb_mem.v | wb_v)) state <= HALTED;
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign pc_hold     = rst & stall;
  assign ifid_hold   = rst & stall;
  assign idex_bubble = rst & stall;
  assign ifid_flush  = rst & br_taken & ~stall;
  assign fwd1_sel    = f1;
  assign fwd2_sel    = f2;
  assign halted = rst & ((state == HALTED) |
                  ((state == DRAIN) &
                   ~(sb_ex.v | sb_mem.v | wb_v)));

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] sc;
  logic [CNT_W-1:0] fc;
  logic             cnt_st;

  assign cnt_st = stall & ((state == LSTALL) |
                           (state == BSTALL) |
                           ((state == RUN) & ~hz_halt));

  // Saturating counters; nothing counts once drained, so they hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc <= '0;
      fc <= '0;
    end else begin
      if (cnt_st && (sc != '1)) sc <= sc + CNT_W'(1);
      if (ifid_flush && (fc != '1)) fc <= fc + CNT_W'(1);
    end
  end

  assign stall_cnt = sc;
  assign flush_cnt = fc;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: scoreboard bench for hazard_fwd_ctrl.
// Instruction-level pipeline model predicts every cycle's outputs.
module tb_hazard_fwd_ctrl;
  localparam int RA_W  = 4;
  localparam int LAT   = 3;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_use1, id_use2, id_wr, id_wr2;
  logic id_load, id_branch, br_taken, id_halt;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd, id_rd2;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, halted;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .RA_W(RA_W), .LOAD_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_use1(id_use1),
    .id_rs2(id_rs2), .id_use2(id_use2),
    .id_rd(id_rd), .id_wr(id_wr),
    .id_rd2(id_rd2), .id_wr2(id_wr2),
    .id_load(id_load), .id_branch(id_branch),
    .br_taken(br_taken), .id_halt(id_halt),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic v, u1, u2, wr, wr2, ld, br, halt;
    logic [3:0] rs1, rs2, rd, rd2;
  } ins_t;

  // model: instructions in EX/MEM/WB, remaining load stalls, drain flag
  ins_t pipe [3];
  int   ls_left;
  bit   drain;
  logic [1:0] f1m, f2m;
  int   m_stall, m_flush;
  logic [8:0] expq [$];
  int   checks, errors;

  function automatic bit writes(input ins_t e,
                                input logic [3:0] r);
    return e.v && ((e.wr && e.rd == r) ||
                   (e.wr2 && e.rd2 == r));
  endfunction

  function automatic ins_t alu(int rd, int a, int b);
    ins_t i = '0;
    i.v = 1; i.u1 = 1; i.u2 = 1; i.wr = 1;
    i.rd = 4'(rd); i.rs1 = 4'(a); i.rs2 = 4'(b);
    return i;
  endfunction

  function automatic ins_t ldi(int rd, int a);
    ins_t i = '0;
    i.v = 1; i.u1 = 1; i.wr = 1; i.ld = 1;
    i.rd = 4'(rd); i.rs1 = 4'(a);
    return i;
  endfunction

  function automatic ins_t brq(int a, int b);
    ins_t i = '0;
    i.v = 1; i.u1 = 1; i.u2 = 1; i.br = 1;
    i.rs1 = 4'(a); i.rs2 = 4'(b);
    return i;
  endfunction

  function automatic ins_t mul(int rd, int rd2, int a, int b);
    ins_t i = alu(rd, a, b);
    i.wr2 = 1; i.rd2 = 4'(rd2);
    return i;
  endfunction

  function automatic ins_t hlt();
    ins_t i = '0;
    i.v = 1; i.halt = 1;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i = '0;
    i.v   = ($urandom_range(7) != 0);
    i.rs1 = 4'($urandom_range(3));
    i.rs2 = 4'($urandom_range(3));
    i.rd  = 4'($urandom_range(3));
    i.rd2 = 4'($urandom_range(3));
    i.u1  = 1'($urandom_range(1));
    i.u2  = 1'($urandom_range(1));
    i.br  = ($urandom_range(4) == 0);
    i.ld  = !i.br && ($urandom_range(3) == 0);
    i.wr  = !i.br && (i.ld || $urandom_range(3) != 0);
    i.wr2 = i.wr && !i.ld && ($urandom_range(3) == 0);
    return i;
  endfunction

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic drive(input ins_t i, input bit tk);
    id_valid = i.v;   id_halt = i.halt;
    id_rs1 = i.rs1;   id_use1 = i.u1;
    id_rs2 = i.rs2;   id_use2 = i.u2;
    id_rd = i.rd;     id_wr = i.wr;
    id_rd2 = i.rd2;   id_wr2 = i.wr2;
    id_load = i.ld;   id_branch = i.br;
    br_taken = tk;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    ls_left = 0; drain = 0;
    f1m = 0; f2m = 0;
    m_stall = 0; m_flush = 0;
  endtask

  // one cycle: drive ID, predict outputs, push, advance model
  task automatic cyc(input ins_t i, input bit tk,
                     output bit took);
    bit st, cs, fl, ho, adv;
    bit h1e, h2e, h1m, h2m;
    @(negedge clk);
    drive(i, tk);
    #2;
    h1e = i.u1 && writes(pipe[0], i.rs1);
    h2e = i.u2 && writes(pipe[0], i.rs2);
    h1m = i.u1 && writes(pipe[1], i.rs1);
    h2m = i.u2 && writes(pipe[1], i.rs2);
    ho = drain && !pipe[0].v && !pipe[1].v && !pipe[2].v;
    st = 0; cs = 0; took = 0;
    if (drain) st = 1;
    else if (ls_left > 0) begin
      st = 1; cs = 1; ls_left--;
    end else if (i.v && i.halt) begin
      st = 1; drain = 1; took = 1;
    end else if (i.v && pipe[0].ld && (h1e || h2e)) begin
      st = 1; cs = 1; ls_left = LAT - 1;
    end else if (i.v && i.br && (h1e || h2e || h1m || h2m)) begin
      st = 1; cs = 1;
    end else took = 1;
    fl = tk && !st;
    adv = i.v && !st;
    expq.push_back({st, st, fl, st, f1m, f2m, ho});
    m_stall += int'(cs);
    m_flush += int'(fl);
    if (adv) begin
      f1m = h1e ? 2'd1 : (h1m ? 2'd2 : 2'd0);
      f2m = h2e ? 2'd1 : (h2m ? 2'd2 : 2'd0);
    end else begin
      f1m = 0; f2m = 0;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = adv ? i : '0;
  endtask

  task automatic send(input ins_t i, input bit tk,
                      output int tries);
    bit took;
    tries = 0;
    do begin
      cyc(i, tk, took);
      tries++;
    end while (!took && tries < 20);
    if (!took) begin
      checks++; errors++;
      $display("FAIL send_bound tries=%0d need<20", tries);
    end
  endtask

  task automatic do_reset(input bit chk);
    @(posedge clk); #1;
    if (chk) check("pre_rst_hold", int'(pc_hold), 1);
`ifdef HZ_PERF_CNT_EN
    check("stall_cnt", int'(stall_cnt), m_stall);
    check("flush_cnt", int'(flush_cnt), m_flush);
`else
    check("stall_cnt", int'(stall_cnt), 0);
    check("flush_cnt", int'(flush_cnt), 0);
`endif
    rst = 1'b0;
    #1;
    check("rst_outs", int'({pc_hold, ifid_hold, ifid_flush,
          idex_bubble, fwd1_sel, fwd2_sel, halted}), 0);
    check("rst_cnts", int'(stall_cnt) + int'(flush_cnt), 0);
    model_reset();
    expq.delete();
    drive('0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: compare every presented cycle against the queue
  initial begin
    logic [8:0] e, g;
    forever begin
      @(negedge clk);
      #4;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {pc_hold, ifid_hold, ifid_flush, idex_bubble,
             fwd1_sel, fwd2_sel, halted};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outs t=%0t got=%b exp=%b",
                   $time, g, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tr, n;
    bit tk, took;
    ins_t x;
    checks = 0; errors = 0;
    drive('0, 0);
    model_reset();
    #1;
    check("init_outs", int'({pc_hold, ifid_hold, ifid_flush,
          idex_bubble, fwd1_sel, fwd2_sel, halted}), 0);
    check("init_cnts", int'(stall_cnt) + int'(flush_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    send(alu(3, 1, 2), 0, tr);
    send(alu(8, 3, 1), 0, tr);
    cyc('0, 0, took); #1;
    check("fwd1_ex", int'(fwd1_sel), 1);

    send(alu(3, 1, 2), 0, tr);
    send('0, 0, tr);
    send(alu(8, 3, 1), 0, tr);
    cyc('0, 0, took); #1;
    check("fwd1_mem", int'(fwd1_sel), 2);

    send(ldi(5, 11), 0, tr);
    send(alu(9, 12, 5), 0, tr);
    check("load_stalls", tr - 1, LAT);
    cyc('0, 0, took); #1;
    check("load_fwd2", int'(fwd2_sel), (LAT == 1) ? 2 : 0);

    send(alu(4, 1, 1), 0, tr);
    send(brq(2, 4), 1, tr); #1;
    check("br_flush", int'(ifid_flush), 1);
    check("br_stalls", tr - 1, 2);

    send(mul(6, 7, 1, 1), 0, tr);
    send(alu(10, 13, 7), 0, tr);
    cyc('0, 0, took); #1;
    check("fwd2_wr2", int'(fwd2_sel), 1);

    send(alu(1, 12, 13), 0, tr);
    send(ldi(2, 14), 0, tr);
    send(hlt(), 0, tr);
    n = 0;
    do begin
      cyc('0, 0, took);
      n++;
      #1;
    end while (!halted && n < 10);
    check("halt_lat", n, 3);
    check("halt_hold", int'(pc_hold), 1);
    do_reset(0);

    send(ldi(5, 11), 0, tr);
    cyc(alu(9, 12, 5), 0, took);
    do_reset(1);

    for (int ep = 0; ep < 6; ep++) begin
      for (int k = 0; k < 200; k++) begin
        x = rnd_ins();
        if (k > 40 && $urandom_range(60) == 0) x = hlt();
        tk = ($urandom_range(3) == 0);
        send(x, tk, tr);
        if (x.v && x.halt) break;
      end
      repeat (5) cyc('0, 0, took);
      do_reset(0);
    end

    check("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
